// File: rtl/spi_adc_responder_if.sv
// SPI wires between the sonar SPI controller (master) and the ADC-side responder (slave).
// The port names follow the responder's point of view.
interface spi_adc_responder_if;
  logic chip_clk_in;
  logic chip_sel_in;
  logic chip_data_out;

  modport master (
    output chip_clk_in,
    output chip_sel_in,
    input  chip_data_out
  );

  modport slave (
    input  chip_clk_in,
    input  chip_sel_in,
    output chip_data_out
  );
endinterface

// File: rtl/spi_adc_responder.sv
// ADC-side SPI responder: serves one parallel sample per chip-select frame, MSB first,
// to the sonar SPI controller, with stale/short-frame flags and saturating counters.
module spi_adc_responder #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 0,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  spi_adc_responder_if.slave    spi,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid_in,
  output logic                  frame_done_out,
  output logic                  short_frame_out,
  output logic                  stale_out,
  output logic [CNT_WIDTH-1:0]  frame_count_out,
  output logic [CNT_WIDTH-1:0]  overrun_count_out
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t                 state_q;
  logic [DATA_WIDTH-1:0]  shiftReg_q;
  logic [DATA_WIDTH-1:0]  pending_q;
  logic                   pendingFull_q;
  logic [DATA_WIDTH-1:0]  lastSent_q;
  logic [DATA_WIDTH-1:0]  served_q;
  logic [BW-1:0]          bitCnt_q;
  logic                   dataOut_q;
  logic                   frameDone_q;
  logic                   shortFrame_q;
  logic                   stale_q;
  logic [CNT_WIDTH-1:0]   frameCount_q;
  logic [CNT_WIDTH-1:0]   overrunCount_q;
  logic                   sclkPrev_q;
  logic                   csPrev_q;

  logic                   sclkS;
  logic                   csS;
  logic                   csFall;
  logic                   csRise;
  logic                   sclkFall;
  logic                   frameStart;
  logic [DATA_WIDTH-1:0]  served_d;
  logic [CNT_WIDTH-1:0]   frameCount_d;
  logic [CNT_WIDTH-1:0]   overrunCount_d;

  // Zero stages means the controller runs off clk_in and needs no resynchronisation.
  generate
    if (SYNC_STAGES == 0) begin : gNoSync
      assign sclkS = spi.chip_clk_in;
      assign csS   = spi.chip_sel_in;
    end else begin : gSync
      logic [SYNC_STAGES-1:0] sclkSync_q;
      logic [SYNC_STAGES-1:0] csSync_q;

      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          sclkSync_q <= '0;
          csSync_q   <= '0;
        end else begin
          sclkSync_q[0] <= spi.chip_clk_in;
          csSync_q[0]   <= spi.chip_sel_in;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sclkSync_q[i] <= sclkSync_q[i-1];
            csSync_q[i]   <= csSync_q[i-1];
          end
        end
      end

      assign sclkS = sclkSync_q[SYNC_STAGES-1];
      assign csS   = csSync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign csFall     = csPrev_q & ~csS;
  assign csRise     = ~csPrev_q & csS;
  assign sclkFall   = sclkPrev_q & ~sclkS;
  assign frameStart = csFall && (state_q == IDLE);

  // A strobe coinciding with the frame start bypasses the pending register.
  always_comb begin
    served_d = lastSent_q;
    if (sample_valid_in) begin
      served_d = sample_in;
    end else if (pendingFull_q) begin
      served_d = pending_q;
    end
    frameCount_d   = (frameCount_q == '1) ? frameCount_q : frameCount_q + CNT_WIDTH'(1);
    overrunCount_d = (overrunCount_q == '1) ? overrunCount_q : overrunCount_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= IDLE;
      shiftReg_q     <= '0;
      pending_q      <= '0;
      pendingFull_q  <= 1'b0;
      lastSent_q     <= '0;
      served_q       <= '0;
      bitCnt_q       <= '0;
      dataOut_q      <= 1'b0;
      frameDone_q    <= 1'b0;
      shortFrame_q   <= 1'b0;
      stale_q        <= 1'b0;
      frameCount_q   <= '0;
      overrunCount_q <= '0;
      sclkPrev_q     <= 1'b0;
      csPrev_q       <= 1'b0;
    end else begin
      frameDone_q  <= 1'b0;
      shortFrame_q <= 1'b0;
      sclkPrev_q   <= sclkS;
      csPrev_q     <= csS;

      if (frameStart) begin
        pendingFull_q <= 1'b0;
      end else if (sample_valid_in) begin
        pending_q     <= sample_in;
        pendingFull_q <= 1'b1;
        if (pendingFull_q) begin
          overrunCount_q <= overrunCount_d;
        end
      end

      case (state_q)
        IDLE: begin
          dataOut_q <= 1'b0;
          if (csFall) begin
            shiftReg_q <= served_d;
            served_q   <= served_d;
            stale_q    <= ~(pendingFull_q | sample_valid_in);
            bitCnt_q   <= '0;
            dataOut_q  <= served_d[DATA_WIDTH-1];
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          if (csRise) begin
            shortFrame_q <= 1'b1;
            dataOut_q    <= 1'b0;
            state_q      <= IDLE;
          end else if (sclkFall) begin
            shiftReg_q <= shiftReg_q << 1;
            bitCnt_q   <= bitCnt_q + BW'(1);
            if (bitCnt_q == LAST_BIT) begin
              dataOut_q <= 1'b0;
              state_q   <= DONE;
            end else begin
              dataOut_q <= shiftReg_q[DATA_WIDTH-2];
            end
          end
        end
        DONE: begin
          dataOut_q <= 1'b0;
          if (csRise) begin
            frameDone_q  <= 1'b1;
            frameCount_q <= frameCount_d;
            lastSent_q   <= served_q;
            state_q      <= IDLE;
          end
        end
        default: begin
          dataOut_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign spi.chip_data_out = dataOut_q;
  assign frame_done_out    = frameDone_q;
  assign short_frame_out   = shortFrame_q;
  assign stale_out         = stale_q;
  assign frame_count_out   = frameCount_q;
  assign overrun_count_out = overrunCount_q;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Bench for spi_adc_responder: a behavioural SPI controller drives two responders
// (same-domain, and two-stage synchronised with narrow counters) against a sample-queue model.
module tb_spi_adc_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dclk = 1'b0;
  logic        cs = 1'b1;
  logic        valid = 1'b0;
  logic [15:0] sample = '0;

  always #5 clk = ~clk;

  spi_adc_responder_if if0();
  spi_adc_responder_if if2();

  assign if0.chip_clk_in = dclk;
  assign if0.chip_sel_in = cs;
  assign if2.chip_clk_in = dclk;
  assign if2.chip_sel_in = cs;

  logic        done0, short0, stale0;
  logic        done2, short2, stale2;
  logic [15:0] fc0, oc0;
  logic [1:0]  fc2, oc2;

  spi_adc_responder #(.DATA_WIDTH(16), .SYNC_STAGES(0), .CNT_WIDTH(16)) dut0 (
    .clk_in(clk), .rst_in(rst), .spi(if0.slave),
    .sample_in(sample), .sample_valid_in(valid),
    .frame_done_out(done0), .short_frame_out(short0), .stale_out(stale0),
    .frame_count_out(fc0), .overrun_count_out(oc0)
  );

  spi_adc_responder #(.DATA_WIDTH(16), .SYNC_STAGES(2), .CNT_WIDTH(2)) dut2 (
    .clk_in(clk), .rst_in(rst), .spi(if2.slave),
    .sample_in(sample), .sample_valid_in(valid),
    .frame_done_out(done2), .short_frame_out(short2), .stale_out(stale2),
    .frame_count_out(fc2), .overrun_count_out(oc2)
  );

  int checks = 0;
  int errors = 0;
  int doneCnt0 = 0, shortCnt0 = 0, doneCnt2 = 0, shortCnt2 = 0;

  // Pulse outputs are tallied on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (done0)  doneCnt0++;
    if (short0) shortCnt0++;
    if (done2)  doneCnt2++;
    if (short2) shortCnt2++;
  end

  bit useDut2 = 1'b0;
  int period  = 5;
  int syncOff = 0;
  int cntMax  = 65535;

  wire obsData  = useDut2 ? if2.chip_data_out : if0.chip_data_out;
  wire obsStale = useDut2 ? stale2 : stale0;

  function automatic int obsFrames();
    return useDut2 ? int'(fc2) : int'(fc0);
  endfunction

  function automatic int obsOverruns();
    return useDut2 ? int'(oc2) : int'(oc0);
  endfunction

  function automatic int obsDone();
    return useDut2 ? doneCnt2 : doneCnt0;
  endfunction

  function automatic int obsShort();
    return useDut2 ? shortCnt2 : shortCnt0;
  endfunction

  // Reference model: one-deep pending slot, last completed sample, saturating counts.
  bit          mPendFull;
  logic [15:0] mPend;
  logic [15:0] mLast;
  int          mFrames;
  int          mOver;
  bit          mStale;

  function automatic int satInc(input int v);
    return (v >= cntMax) ? v : v + 1;
  endfunction

  task automatic modelReset();
    mPendFull = 1'b0;
    mPend     = '0;
    mLast     = '0;
    mFrames   = 0;
    mOver     = 0;
    mStale    = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic loadSample(input logic [15:0] v);
    sample = v;
    valid  = 1'b1;
    tick(1);
    valid  = 1'b0;
    if (mPendFull) mOver = satInc(mOver);
    mPend     = v;
    mPendFull = 1'b1;
  endtask

  // One controller frame of nBits clocks; cipo is captured as dclk rises.
  task automatic runFrame(input int nBits, input bit bypass, input logic [15:0] bv,
                          output logic [15:0] cap, output logic [15:0] expd);
    int hi;
    int lo;
    logic [15:0] served;
    hi = period / 2;
    lo = period - hi;
    served    = bypass ? bv : (mPendFull ? mPend : mLast);
    mStale    = !(bypass || mPendFull);
    mPendFull = 1'b0;
    cs = 1'b0;
    if (bypass) begin
      tick(syncOff);
      sample = bv;
      valid  = 1'b1;
      tick(1);
      valid  = 1'b0;
    end
    tick(period);
    cap = '0;
    for (int i = 0; i < nBits; i++) begin
      dclk = 1'b1;
      cap  = {cap[14:0], obsData};
      tick(hi);
      dclk = 1'b0;
      tick(lo);
    end
    tick(period);
    cs = 1'b1;
    tick(syncOff + 4);
    if (nBits == 16) begin
      mFrames = satInc(mFrames);
      mLast   = served;
      expd    = served;
    end else begin
      expd = served >> (16 - nBits);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cs  = 1'b1;
    dclk = 1'b0;
    valid = 1'b0;
    tick(2);
    rst = 1'b0;
    modelReset();
    tick(syncOff + 3);
    checks++;
    if (obsData !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_data: got %b expected 0", obsData);
    end
    checks++;
    if (obsFrames() !== 0 || obsOverruns() !== 0) begin
      errors++; $display("[TB] FAIL reset_counts: got %0d/%0d expected 0/0", obsFrames(), obsOverruns());
    end
    checks++;
    if (obsStale !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_stale: got %b expected 0", obsStale);
    end
  endtask

  task automatic test_single_frame();
    logic [15:0] cap, expd;
    int d0;
    d0 = obsDone();
    loadSample(16'hA5C3);
    runFrame(16, 1'b0, '0, cap, expd);
    checks++;
    if (cap !== expd) begin
      errors++; $display("[TB] FAIL single_data: got %h expected %h", cap, expd);
    end
    checks++;
    if (obsDone() - d0 !== 1) begin
      errors++; $display("[TB] FAIL single_done_pulses: got %0d expected 1", obsDone() - d0);
    end
    checks++;
    if (obsFrames() !== mFrames || obsStale !== mStale) begin
      errors++; $display("[TB] FAIL single_frames_stale: got %0d/%b expected %0d/%b",
                         obsFrames(), obsStale, mFrames, mStale);
    end
  endtask

  task automatic test_stale_reserve();
    logic [15:0] cap, expd;
    runFrame(16, 1'b0, '0, cap, expd);
    checks++;
    if (cap !== expd) begin
      errors++; $display("[TB] FAIL stale_data: got %h expected %h", cap, expd);
    end
    checks++;
    if (obsStale !== mStale || obsFrames() !== mFrames) begin
      errors++; $display("[TB] FAIL stale_flag_frames: got %b/%0d expected %b/%0d",
                         obsStale, obsFrames(), mStale, mFrames);
    end
  endtask

  task automatic test_overrun();
    logic [15:0] cap, expd;
    loadSample(16'h1111);
    loadSample(16'h2222);
    runFrame(16, 1'b0, '0, cap, expd);
    checks++;
    if (cap !== expd) begin
      errors++; $display("[TB] FAIL overrun_data: got %h expected %h", cap, expd);
    end
    checks++;
    if (obsOverruns() !== mOver) begin
      errors++; $display("[TB] FAIL overrun_count: got %0d expected %0d", obsOverruns(), mOver);
    end
  endtask

  task automatic test_short_frame();
    logic [15:0] cap, expd;
    int s0, d0;
    s0 = obsShort();
    d0 = obsDone();
    runFrame(7, 1'b0, '0, cap, expd);
    checks++;
    if (cap !== expd) begin
      errors++; $display("[TB] FAIL short_data: got %h expected %h", cap, expd);
    end
    checks++;
    if (obsShort() - s0 !== 1 || obsDone() - d0 !== 0 || obsFrames() !== mFrames) begin
      errors++; $display("[TB] FAIL short_pulses: got short %0d done %0d frames %0d expected 1 0 %0d",
                         obsShort() - s0, obsDone() - d0, obsFrames(), mFrames);
    end
    runFrame(16, 1'b0, '0, cap, expd);
    checks++;
    if (cap !== expd || obsFrames() !== mFrames) begin
      errors++; $display("[TB] FAIL short_refill: got %h/%0d expected %h/%0d",
                         cap, obsFrames(), expd, mFrames);
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] cap, expd;
    int s0;
    loadSample(16'(($urandom & 16'hFFFF) | 16'h0040));
    cs = 1'b0;
    tick(period);
    for (int i = 0; i < 9; i++) begin
      dclk = 1'b1;
      tick(period / 2);
      dclk = 1'b0;
      tick(period - period / 2);
    end
    rst = 1'b1;
    tick(1);
    checks++;
    if (obsData !== 1'b0 || obsFrames() !== 0 || obsOverruns() !== 0) begin
      errors++; $display("[TB] FAIL midreset_clear: got data %b counts %0d/%0d expected 0 0/0",
                         obsData, obsFrames(), obsOverruns());
    end
    s0 = obsShort();
    rst = 1'b0;
    modelReset();
    tick(syncOff + 3);
    cs = 1'b1;
    tick(syncOff + 3);
    checks++;
    if (obsShort() - s0 !== 0 || obsData !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_no_frame: got short %0d data %b expected 0 0",
                         obsShort() - s0, obsData);
    end
    loadSample(16'($urandom));
    runFrame(16, 1'b0, '0, cap, expd);
    checks++;
    if (cap !== expd || obsFrames() !== mFrames || obsStale !== mStale) begin
      errors++; $display("[TB] FAIL midreset_next: got %h/%0d/%b expected %h/%0d/%b",
                         cap, obsFrames(), obsStale, expd, mFrames, mStale);
    end
  endtask

  task automatic test_random();
    logic [15:0] cap, expd;
    int nl, nb;
    for (int it = 0; it < 8; it++) begin
      nl = $urandom_range(0, 2);
      for (int k = 0; k < nl; k++) loadSample(16'($urandom));
      nb = ($urandom_range(0, 3) != 0) ? 16 : $urandom_range(1, 15);
      runFrame(nb, 1'b0, '0, cap, expd);
      checks++;
      if (cap !== expd || obsStale !== mStale) begin
        errors++; $display("[TB] FAIL random_data[%0d]: got %h/%b expected %h/%b",
                           it, cap, obsStale, expd, mStale);
      end
      checks++;
      if (obsFrames() !== mFrames || obsOverruns() !== mOver) begin
        errors++; $display("[TB] FAIL random_counts[%0d]: got %0d/%0d expected %0d/%0d",
                           it, obsFrames(), obsOverruns(), mFrames, mOver);
      end
    end
  endtask

  task automatic test_bypass();
    logic [15:0] cap, expd;
    loadSample(16'h0001);
    runFrame(16, 1'b1, 16'hBEEF, cap, expd);
    checks++;
    if (cap !== expd || obsStale !== mStale) begin
      errors++; $display("[TB] FAIL bypass_data: got %h/%b expected %h/%b", cap, obsStale, expd, mStale);
    end
    checks++;
    if (obsOverruns() !== mOver) begin
      errors++; $display("[TB] FAIL bypass_overrun: got %0d expected %0d", obsOverruns(), mOver);
    end
    runFrame(16, 1'b0, '0, cap, expd);
    checks++;
    if (cap !== expd || obsStale !== mStale) begin
      errors++; $display("[TB] FAIL bypass_pending_cleared: got %h/%b expected %h/%b",
                         cap, obsStale, expd, mStale);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] cap, expd;
    for (int k = 0; k < 6; k++) loadSample(16'($urandom));
    checks++;
    if (obsOverruns() !== mOver) begin
      errors++; $display("[TB] FAIL sat_overrun: got %0d expected %0d", obsOverruns(), mOver);
    end
    for (int k = 0; k < 4; k++) runFrame(16, 1'b0, '0, cap, expd);
    checks++;
    if (obsFrames() !== mFrames || cap !== expd) begin
      errors++; $display("[TB] FAIL sat_frames: got %0d/%h expected %0d/%h", obsFrames(), cap, mFrames, expd);
    end
  endtask

  initial begin
    modelReset();
    tick(1);
    useDut2 = 1'b0; period = 5; syncOff = 0; cntMax = 65535;
    test_reset();
    test_single_frame();
    test_stale_reserve();
    test_overrun();
    test_short_frame();
    test_reset_midframe();
    test_random();
    test_bypass();

    useDut2 = 1'b1; period = 8; syncOff = 2; cntMax = 3;
    test_reset();
    test_single_frame();
    test_bypass();
    test_saturation();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
